// File: rtl/deco_stage.sv
// rtl/deco_stage.sv - RV32I/RV64I decode stage with a two-entry skid buffer.
// Optional DECO_ILLEGAL_EN keeps an illegal-opcode flag per record.
module deco_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       out_op,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [3:0]       out_type,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      instr_q [2];
  logic [PC_W-1:0]  pc_q    [2];
  logic [3:0]       type_q  [2];
  logic [XLEN-1:0]  imm_q   [2];

  logic            push, pop, tail;
  logic [3:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic [31:0]     head_instr;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  // Tail sits one past the head when a record is already held.
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    dec_type = 4'd0;
    dec_imm  = '0;
    case (in_instr[6:0])
      7'b0110011: dec_type = 4'd1;
      7'b0010011: begin dec_type = 4'd2; dec_imm = XLEN'($signed(in_instr[31:20])); end
      7'b0110111: begin dec_type = 4'd3; dec_imm = XLEN'($signed({in_instr[31:12], 12'b0})); end
      7'b1100011: begin
        dec_type = 4'd4;
        dec_imm  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      end
      7'b1100111: begin dec_type = 4'd5; dec_imm = XLEN'($signed(in_instr[31:20])); end
      7'b1101111: begin
        dec_type = 4'd6;
        dec_imm  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      end
      7'b0000011: begin dec_type = 4'd7; dec_imm = XLEN'($signed(in_instr[31:20])); end
      7'b0100011: begin dec_type = 4'd8; dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]})); end
      7'b0010111: begin dec_type = 4'd9; dec_imm = XLEN'($signed({in_instr[31:12], 12'b0})); end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) head_d = ~head_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        type_q[i]  <= '0;
        imm_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      if (pop) cnt_q <= cnt_q + 1'b1;
      if (push) begin
        instr_q[tail] <= in_instr;
        pc_q[tail]    <= in_pc;
        type_q[tail]  <= dec_type;
        imm_q[tail]   <= dec_imm;
      end
    end
  end

`ifdef DECO_ILLEGAL_EN
  logic ill_q [2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q[0] <= 1'b0;
      ill_q[1] <= 1'b0;
    end else if (push) begin
      ill_q[tail] <= (dec_type == 4'd0);
    end
  end
  assign out_illegal = ill_q[head_q];
`else
  assign out_illegal = 1'b0;
`endif

  assign head_instr = instr_q[head_q];
  assign out_pc     = pc_q[head_q];
  assign out_type   = type_q[head_q];
  assign out_imm    = imm_q[head_q];
  assign out_op     = head_instr[6:0];
  assign out_funct3 = head_instr[14:12];
  assign out_funct7 = head_instr[31:25];
  assign out_rs1    = head_instr[19:15];
  assign out_rs2    = head_instr[24:20];
  assign out_rd     = head_instr[11:7];
  assign dec_count  = cnt_q;

endmodule

// File: tb/tb_deco_stage.sv
// tb/tb_deco_stage.sv - scoreboard bench for deco_stage (XLEN=32 main DUT, XLEN=64 side DUT).
module tb_deco_stage;

`ifdef DECO_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_op, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_type;
  logic [15:0] dec_count;

  logic        w_in_valid = 1'b0;
  logic [31:0] w_in_instr = '0;
  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [31:0] w_out_pc;
  logic [63:0] w_out_imm;
  logic [6:0]  w_out_op, w_out_funct7;
  logic [2:0]  w_out_funct3;
  logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
  logic [3:0]  w_out_type;
  logic [15:0] w_dec_count;

  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [10];
  vec_t        sb [$];
  vec_t        cur_exp;
  logic [15:0] exp_cnt = '0;
  logic [15:0] saved_cnt;

  always #5 clk = ~clk;

  deco_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op), .out_funct7(out_funct7),
    .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_type(out_type), .out_imm(out_imm), .out_illegal(out_illegal), .dec_count(dec_count)
  );

  deco_stage #(.XLEN(64), .PC_W(32), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_instr(w_in_instr), .in_pc(32'h0000_2000), .flush(1'b0), .out_valid(w_out_valid),
    .out_ready(1'b1), .out_pc(w_out_pc), .out_op(w_out_op), .out_funct7(w_out_funct7),
    .out_funct3(w_out_funct3), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
    .out_type(w_out_type), .out_imm(w_out_imm), .out_illegal(w_out_illegal), .dec_count(w_dec_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: model occupancy is the scoreboard depth; head is compared every valid cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      chk("dec_count", dec_count, exp_cnt);
      chk("in_ready", in_ready, sb.size() < 2);
      chk("out_valid", out_valid, sb.size() != 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_unexpected: got pc %0h expected no record", out_pc);
        end else begin
          chk("out_pc", out_pc, sb[0].pc);
          chk("out_type", out_type, sb[0].typ);
          chk("out_imm", out_imm, sb[0].imm);
          chk("out_rd", out_rd, sb[0].rd);
          chk("out_rs1", out_rs1, sb[0].rs1);
          chk("out_rs2", out_rs2, sb[0].rs2);
          chk("out_illegal", out_illegal, ILL_EN && (sb[0].typ == 4'd0));
          if (out_ready) begin
            void'(sb.pop_front());
            exp_cnt = exp_cnt + 16'd1;
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic push_vec(input int idx);
    bit acc = 1'b0;
    cur_exp  = vecs[idx];
    in_instr = vecs[idx].instr;
    in_pc    = vecs[idx].pc;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: vector %0d not accepted within 50 cycles", idx);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'hFFB10093, 32'h100, 4'd2, 32'hFFFFFFFB, 5'd1,  5'd2,  5'd27};
    vecs[1] = '{32'hFE000EE3, 32'h104, 4'd4, 32'hFFFFFFFC, 5'd29, 5'd0,  5'd0};
    vecs[2] = '{32'h123452B7, 32'h108, 4'd3, 32'h12345000, 5'd5,  5'd8,  5'd3};
    vecs[3] = '{32'h00612423, 32'h10C, 4'd8, 32'h00000008, 5'd8,  5'd2,  5'd6};
    vecs[4] = '{32'h0080006F, 32'h110, 4'd6, 32'h00000008, 5'd0,  5'd0,  5'd8};
    vecs[5] = '{32'hFFFFF097, 32'h114, 4'd9, 32'hFFFFF000, 5'd1,  5'd31, 5'd31};
    vecs[6] = '{32'hFFC42183, 32'h118, 4'd7, 32'hFFFFFFFC, 5'd3,  5'd8,  5'd28};
    vecs[7] = '{32'h000080E7, 32'h11C, 4'd5, 32'h00000000, 5'd1,  5'd1,  5'd0};
    vecs[8] = '{32'h002081B3, 32'h120, 4'd1, 32'h00000000, 5'd3,  5'd1,  5'd2};
    vecs[9] = '{32'h00000000, 32'h124, 4'd0, 32'h00000000, 5'd0,  5'd0,  5'd0};

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_dec_count", dec_count, 16'd0);
    chk("rst_out_type", out_type, 4'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_illegal", out_illegal, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    out_ready = 1'b1;
    push_vec(0);
    idle(2);
    chk("addi_dec_count", dec_count, 16'd1);

    push_vec(1);
    push_vec(2);
    push_vec(3);
    idle(3);

    out_ready = 1'b0;
    fork
      begin
        push_vec(4);
        push_vec(5);
        push_vec(6);
      end
      begin
        idle(5);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_head_pc", out_pc, 32'h110);
        out_ready = 1'b1;
      end
    join
    idle(4);

    out_ready = 1'b0;
    push_vec(7);
    push_vec(8);
    chk("full_in_ready", in_ready, 1'b0);
    saved_cnt = dec_count;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vecs[9].instr;
    in_pc     = vecs[9].pc;
    cur_exp   = vecs[9];
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_dec_count", dec_count, saved_cnt);

    out_ready = 1'b1;
    push_vec(9);
    idle(3);

    w_in_instr = 32'h800002B7;
    w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    chk("x64_out_valid", w_out_valid, 1'b1);
    chk("x64_out_type", w_out_type, 4'd3);
    chk("x64_out_imm", w_out_imm, 64'hFFFFFFFF80000000);
    chk("x64_out_rd", w_out_rd, 5'd5);
    idle(1);
    chk("x64_dec_count", w_dec_count, 16'd1);

    out_ready = 1'b0;
    push_vec(0);
    push_vec(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_dec_count", dec_count, 16'd0);
    chk("midrst_out_type", out_type, 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("end_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
